// File: rtl/decode_issue_if.sv
// Signal bundle between fetch, decode_issue and execute.
// slave is the decode_issue side; master is the fetch/execute (or bench) side.
interface decode_issue_if;
    logic        flush;
    logic        stall_in;
    logic [31:0] pc_in;
    logic [63:0] inst_in;
    logic        interlock;
    logic [31:0] pc_out;
    logic [1:0]  valid_out;
    logic [5:0]  op0;
    logic [5:0]  op1;
    logic [4:0]  rd0;
    logic [4:0]  rd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [4:0]  rb0;
    logic [4:0]  rb1;
    logic [15:0] imm0;
    logic [15:0] imm1;

    modport master (
        output flush, stall_in, pc_in, inst_in,
        input  interlock, pc_out, valid_out, op0, op1,
               rd0, rd1, ra0, ra1, rb0, rb1, imm0, imm1
    );

    modport slave (
        input  flush, stall_in, pc_in, inst_in,
        output interlock, pc_out, valid_out, op0, op1,
               rd0, rd1, ra0, ra1, rb0, rb1, imm0, imm1
    );
endinterface

// File: rtl/decode_issue.sv
// Dual-slot decode/issue stage with load-use scoreboard and intra-bundle split.
// Define DECODE_STATS_EN to add the bubble_cnt/split_cnt statistics outputs.
module decode_issue #(
    parameter int         LOAD_LAT = 2,
    parameter logic [5:0] LD_OP    = 6'h20
) (
    input  logic          clk,
    input  logic          rstn,
`ifdef DECODE_STATS_EN
    output logic [31:0]   bubble_cnt,
    output logic [31:0]   split_cnt,
`endif
    decode_issue_if.slave bus
);
    localparam logic [5:0] NOP_OP = 6'h00;
    localparam logic [2:0] LAT    = 3'(LOAD_LAT);

    typedef enum logic {NORMAL, SPLIT} state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] inst_s0;
    logic [31:0] inst_s1;
    logic [5:0]  op_s0;
    logic [5:0]  op_s1;
    logic [4:0]  rd_s0;
    logic [4:0]  rd_s1;
    logic [4:0]  ra_s0;
    logic [4:0]  ra_s1;
    logic [4:0]  rb_s0;
    logic [4:0]  rb_s1;
    logic [15:0] imm_s0;
    logic [15:0] imm_s1;
    logic        live_s0;
    logic        live_s1;

    logic [2:0]  cnt [32];
    logic [31:0] busy;
    logic        haz0;
    logic        haz1;
    logic        dep;

    logic        issue0;
    logic        issue1;
    logic        bubble;
    logic        lock;
    logic        set0;
    logic        set1;

    assign inst_s0 = bus.inst_in[63:32];
    assign inst_s1 = bus.inst_in[31:0];
    assign op_s0   = inst_s0[31:26];
    assign op_s1   = inst_s1[31:26];
    assign rd_s0   = inst_s0[25:21];
    assign rd_s1   = inst_s1[25:21];
    assign ra_s0   = inst_s0[20:16];
    assign ra_s1   = inst_s1[20:16];
    assign rb_s0   = inst_s0[15:11];
    assign rb_s1   = inst_s1[15:11];
    assign imm_s0  = inst_s0[15:0];
    assign imm_s1  = inst_s1[15:0];
    assign live_s0 = (op_s0 != NOP_OP);
    assign live_s1 = (op_s1 != NOP_OP);

    // r0 is never tracked, so busy[0] stays low and reads of r0 never stall.
    always_comb begin
        busy = '0;
        for (int r = 1; r < 32; r++) begin
            busy[r] = (cnt[r] != 3'd0);
        end
    end

    assign haz0 = live_s0 && (busy[ra_s0] || busy[rb_s0]);
    assign haz1 = live_s1 && (busy[ra_s1] || busy[rb_s1]);
    assign dep  = live_s0 && live_s1 && (rd_s0 != 5'd0) &&
                  ((rd_s0 == ra_s1) || (rd_s0 == rb_s1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= NORMAL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.flush) begin
            state_next = NORMAL;
        end else if (!bus.stall_in) begin
            case (state)
                NORMAL:  if (!haz0 && !haz1 && dep) state_next = SPLIT;
                SPLIT:   if (!haz1) state_next = NORMAL;
                default: state_next = NORMAL;
            endcase
        end
    end

    // In SPLIT, slot0 has already gone, so only slot1 hazards matter.
    always_comb begin
        issue0 = 1'b0;
        issue1 = 1'b0;
        bubble = 1'b0;
        lock   = 1'b0;
        if (rstn && !bus.flush) begin
            if (bus.stall_in) begin
                lock = 1'b1;
            end else begin
                case (state)
                    NORMAL: begin
                        if (haz0 || haz1) begin
                            bubble = 1'b1;
                            lock   = 1'b1;
                        end else if (dep) begin
                            issue0 = 1'b1;
                            lock   = 1'b1;
                        end else begin
                            issue0 = 1'b1;
                            issue1 = 1'b1;
                        end
                    end
                    SPLIT: begin
                        if (haz1) begin
                            bubble = 1'b1;
                            lock   = 1'b1;
                        end else begin
                            issue1 = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.interlock = lock;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.pc_out    <= '0;
            bus.valid_out <= '0;
            bus.op0       <= NOP_OP;
            bus.op1       <= NOP_OP;
            bus.rd0       <= '0;
            bus.rd1       <= '0;
            bus.ra0       <= '0;
            bus.ra1       <= '0;
            bus.rb0       <= '0;
            bus.rb1       <= '0;
            bus.imm0      <= '0;
            bus.imm1      <= '0;
        end else if (bus.flush) begin
            bus.valid_out <= '0;
            bus.op0       <= NOP_OP;
            bus.op1       <= NOP_OP;
        end else if (issue0 || issue1) begin
            bus.pc_out    <= bus.pc_in;
            bus.valid_out <= {issue0 && live_s0, issue1 && live_s1};
            bus.op0       <= issue0 ? op_s0 : NOP_OP;
            bus.op1       <= issue1 ? op_s1 : NOP_OP;
            bus.rd0       <= rd_s0;
            bus.rd1       <= rd_s1;
            bus.ra0       <= ra_s0;
            bus.ra1       <= ra_s1;
            bus.rb0       <= rb_s0;
            bus.rb1       <= rb_s1;
            bus.imm0      <= imm_s0;
            bus.imm1      <= imm_s1;
        end else if (bubble) begin
            bus.valid_out <= '0;
            bus.op0       <= NOP_OP;
            bus.op1       <= NOP_OP;
        end
    end

    assign set0 = issue0 && (op_s0 == LD_OP) && (rd_s0 != 5'd0);
    assign set1 = issue1 && (op_s1 == LD_OP) && (rd_s1 != 5'd0);

    // Counters survive flush: loads already issued still write back.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < 32; r++) begin
                cnt[r] <= '0;
            end
        end else if (!bus.stall_in) begin
            for (int r = 1; r < 32; r++) begin
                if ((set0 && rd_s0 == 5'(r)) || (set1 && rd_s1 == 5'(r))) begin
                    cnt[r] <= LAT;
                end else if (cnt[r] != 3'd0) begin
                    cnt[r] <= cnt[r] - 3'd1;
                end
            end
        end
    end

`ifdef DECODE_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bubble_cnt <= '0;
            split_cnt  <= '0;
        end else begin
            if (bubble) bubble_cnt <= bubble_cnt + 32'd1;
            if (issue0 && !issue1) split_cnt <= split_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: reset, dual issue, load-use bubble, split, flush, stall.
// Statistics outputs are checked only when DECODE_STATS_EN is defined.
module tb_decode_issue;
    localparam logic [5:0] NOP = 6'h00;
    localparam logic [5:0] ADD = 6'h01;
    localparam logic [5:0] SUB = 6'h02;
    localparam logic [5:0] LD  = 6'h20;

    logic clk = 1'b0;
    logic rstn;
    int   checks   = 0;
    int   failures = 0;

`ifdef DECODE_STATS_EN
    logic [31:0] bubble_cnt;
    logic [31:0] split_cnt;
`endif

    decode_issue_if bus ();

    decode_issue #(.LOAD_LAT(2), .LD_OP(6'h20)) dut (
        .clk        (clk),
        .rstn       (rstn),
`ifdef DECODE_STATS_EN
        .bubble_cnt (bubble_cnt),
        .split_cnt  (split_cnt),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] ra, input logic [4:0] rb);
        return {op, rd, ra, rb, 11'h000};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] s0, input logic [31:0] s1);
        bus.pc_in   = pc;
        bus.inst_in = {s0, s1};
        #1;
    endtask

    task automatic test_reset();
        rstn         = 1'b0;
        bus.flush    = 1'b0;
        bus.stall_in = 1'b0;
        bus.pc_in    = $urandom();
        bus.inst_in  = {$urandom(), $urandom()};
        repeat (2) tick();
        checks++; if (bus.interlock !== 1'b0) begin failures++; $display("[TB] FAIL reset_interlock got=%b exp=0", bus.interlock); end
        checks++; if (bus.valid_out !== 2'b00) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=00", bus.valid_out); end
        checks++; if (bus.op0 !== NOP || bus.op1 !== NOP) begin failures++; $display("[TB] FAIL reset_ops got=%h/%h exp=%h", bus.op0, bus.op1, NOP); end
        checks++; if (bus.pc_out !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc got=%h exp=0", bus.pc_out); end
        checks++; if (bus.rd0 !== 5'd0 || bus.imm1 !== 16'h0) begin failures++; $display("[TB] FAIL reset_fields got rd0=%0d imm1=%h exp 0", bus.rd0, bus.imm1); end
`ifdef DECODE_STATS_EN
        checks++; if (bubble_cnt !== 32'd0 || split_cnt !== 32'd0) begin failures++; $display("[TB] FAIL reset_stats got=%0d/%0d exp=0/0", bubble_cnt, split_cnt); end
`endif
        bus.pc_in   = 32'h0;
        bus.inst_in = 64'h0;
        rstn        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.valid_out !== 2'b00 || bus.pc_out !== 32'h0 || bus.op0 !== NOP || bus.interlock !== 1'b0) begin
                failures++; $display("[TB] FAIL post_reset_hold got valid=%b pc=%h op0=%h il=%b exp 00/0/0/0", bus.valid_out, bus.pc_out, bus.op0, bus.interlock);
            end
        end
    endtask

    task automatic test_pair();
        drive(32'h10, mk(ADD, 5'd1, 5'd2, 5'd3), mk(ADD, 5'd4, 5'd5, 5'd6));
        checks++; if (bus.interlock !== 1'b0) begin failures++; $display("[TB] FAIL pair_interlock got=%b exp=0", bus.interlock); end
        tick();
        checks++; if (bus.valid_out !== 2'b11) begin failures++; $display("[TB] FAIL pair_valid got=%b exp=11", bus.valid_out); end
        checks++; if (bus.rd0 !== 5'd1 || bus.rd1 !== 5'd4) begin failures++; $display("[TB] FAIL pair_rd got=%0d/%0d exp=1/4", bus.rd0, bus.rd1); end
        checks++; if (bus.pc_out !== 32'h10) begin failures++; $display("[TB] FAIL pair_pc got=%h exp=10", bus.pc_out); end
        checks++; if (bus.op0 !== ADD || bus.ra1 !== 5'd5 || bus.rb1 !== 5'd6) begin failures++; $display("[TB] FAIL pair_fields got op0=%h ra1=%0d rb1=%0d exp 01/5/6", bus.op0, bus.ra1, bus.rb1); end
        checks++; if (bus.imm0 !== 16'h1800) begin failures++; $display("[TB] FAIL pair_imm0 got=%h exp=1800", bus.imm0); end
    endtask

    task automatic test_load_use();
        drive(32'h20, mk(LD, 5'd5, 5'd2, 5'd0), 32'h0);
        tick();
        checks++; if (bus.valid_out !== 2'b10 || bus.op0 !== LD || bus.rd0 !== 5'd5) begin failures++; $display("[TB] FAIL ld_issue got valid=%b op0=%h rd0=%0d exp 10/20/5", bus.valid_out, bus.op0, bus.rd0); end
        drive(32'h24, 32'h0, 32'h0);
        tick();
        drive(32'h28, mk(ADD, 5'd9, 5'd5, 5'd1), mk(ADD, 5'd10, 5'd2, 5'd3));
        checks++; if (bus.interlock !== 1'b1) begin failures++; $display("[TB] FAIL ldu_interlock got=%b exp=1", bus.interlock); end
        tick();
        checks++; if (bus.valid_out !== 2'b00 || bus.op0 !== NOP) begin failures++; $display("[TB] FAIL ldu_bubble got valid=%b op0=%h exp 00/00", bus.valid_out, bus.op0); end
        checks++; if (bus.interlock !== 1'b0) begin failures++; $display("[TB] FAIL ldu_release got=%b exp=0", bus.interlock); end
        tick();
        checks++; if (bus.valid_out !== 2'b11 || bus.rd0 !== 5'd9 || bus.pc_out !== 32'h28) begin failures++; $display("[TB] FAIL ldu_issue got valid=%b rd0=%0d pc=%h exp 11/9/28", bus.valid_out, bus.rd0, bus.pc_out); end
`ifdef DECODE_STATS_EN
        checks++; if (bubble_cnt !== 32'd1) begin failures++; $display("[TB] FAIL ldu_bubble_cnt got=%0d exp=1", bubble_cnt); end
`endif
    endtask

    task automatic test_split();
        drive(32'h40, mk(ADD, 5'd7, 5'd1, 5'd1), mk(SUB, 5'd8, 5'd7, 5'd2));
        checks++; if (bus.interlock !== 1'b1) begin failures++; $display("[TB] FAIL split_interlock got=%b exp=1", bus.interlock); end
        tick();
        checks++; if (bus.valid_out !== 2'b10 || bus.op1 !== NOP || bus.rd0 !== 5'd7) begin failures++; $display("[TB] FAIL split_first got valid=%b op1=%h rd0=%0d exp 10/00/7", bus.valid_out, bus.op1, bus.rd0); end
        checks++; if (bus.interlock !== 1'b0) begin failures++; $display("[TB] FAIL split_second_interlock got=%b exp=0", bus.interlock); end
        tick();
        checks++; if (bus.valid_out !== 2'b01 || bus.op0 !== NOP || bus.op1 !== SUB) begin failures++; $display("[TB] FAIL split_second got valid=%b op0=%h op1=%h exp 01/00/02", bus.valid_out, bus.op0, bus.op1); end
        checks++; if (bus.pc_out !== 32'h40 || bus.rd1 !== 5'd8) begin failures++; $display("[TB] FAIL split_second_fields got pc=%h rd1=%0d exp 40/8", bus.pc_out, bus.rd1); end
`ifdef DECODE_STATS_EN
        checks++; if (split_cnt !== 32'd1) begin failures++; $display("[TB] FAIL split_cnt got=%0d exp=1", split_cnt); end
`endif
    endtask

    task automatic test_flush_split();
        drive(32'h50, mk(ADD, 5'd11, 5'd1, 5'd1), mk(SUB, 5'd12, 5'd11, 5'd3));
        tick();
        checks++; if (bus.valid_out !== 2'b10) begin failures++; $display("[TB] FAIL flush_pre got valid=%b exp=10", bus.valid_out); end
        bus.flush = 1'b1;
        #1;
        checks++; if (bus.interlock !== 1'b0) begin failures++; $display("[TB] FAIL flush_interlock got=%b exp=0", bus.interlock); end
        tick();
        checks++; if (bus.valid_out !== 2'b00 || bus.op0 !== NOP || bus.op1 !== NOP) begin failures++; $display("[TB] FAIL flush_bubble got valid=%b ops=%h/%h exp 00/00/00", bus.valid_out, bus.op0, bus.op1); end
        bus.flush = 1'b0;
        drive(32'h60, mk(ADD, 5'd13, 5'd1, 5'd2), mk(ADD, 5'd14, 5'd3, 5'd4));
        checks++; if (bus.interlock !== 1'b0) begin failures++; $display("[TB] FAIL flush_next_interlock got=%b exp=0", bus.interlock); end
        tick();
        checks++; if (bus.valid_out !== 2'b11 || bus.rd0 !== 5'd13 || bus.pc_out !== 32'h60) begin failures++; $display("[TB] FAIL flush_next got valid=%b rd0=%0d pc=%h exp 11/13/60", bus.valid_out, bus.rd0, bus.pc_out); end
`ifdef DECODE_STATS_EN
        checks++; if (split_cnt !== 32'd2 || bubble_cnt !== 32'd1) begin failures++; $display("[TB] FAIL flush_stats got=%0d/%0d exp=1/2", bubble_cnt, split_cnt); end
`endif
    endtask

    task automatic test_stall();
        drive(32'h70, mk(LD, 5'd20, 5'd1, 5'd0), mk(ADD, 5'd21, 5'd1, 5'd2));
        tick();
        checks++; if (bus.valid_out !== 2'b11 || bus.op0 !== LD) begin failures++; $display("[TB] FAIL stall_pre got valid=%b op0=%h exp 11/20", bus.valid_out, bus.op0); end
        bus.stall_in = 1'b1;
        drive(32'h74, mk(ADD, 5'd22, 5'd20, 5'd0), 32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.interlock !== 1'b1) begin failures++; $display("[TB] FAIL stall_interlock got=%b exp=1", bus.interlock); end
            tick();
            checks++; if (bus.valid_out !== 2'b11 || bus.pc_out !== 32'h70 || bus.rd1 !== 5'd21 || bus.op0 !== LD) begin
                failures++; $display("[TB] FAIL stall_hold got valid=%b pc=%h rd1=%0d op0=%h exp 11/70/21/20", bus.valid_out, bus.pc_out, bus.rd1, bus.op0);
            end
        end
        bus.stall_in = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (bus.interlock !== 1'b1) begin failures++; $display("[TB] FAIL frozen_cnt_interlock got=%b exp=1", bus.interlock); end
            tick();
            checks++; if (bus.valid_out !== 2'b00) begin failures++; $display("[TB] FAIL frozen_cnt_bubble got=%b exp=00", bus.valid_out); end
        end
        checks++; if (bus.interlock !== 1'b0) begin failures++; $display("[TB] FAIL stall_release got=%b exp=0", bus.interlock); end
        tick();
        checks++; if (bus.valid_out !== 2'b10 || bus.rd0 !== 5'd22 || bus.pc_out !== 32'h74) begin failures++; $display("[TB] FAIL stall_issue got valid=%b rd0=%0d pc=%h exp 10/22/74", bus.valid_out, bus.rd0, bus.pc_out); end
`ifdef DECODE_STATS_EN
        checks++; if (bubble_cnt !== 32'd3) begin failures++; $display("[TB] FAIL stall_bubble_cnt got=%0d exp=3", bubble_cnt); end
`endif
    endtask

    task automatic test_reset_split();
        drive(32'h80, mk(ADD, 5'd23, 5'd1, 5'd1), mk(SUB, 5'd24, 5'd23, 5'd1));
        tick();
        checks++; if (bus.valid_out !== 2'b10) begin failures++; $display("[TB] FAIL rsplit_pre got=%b exp=10", bus.valid_out); end
        rstn = 1'b0;
        #1;
        checks++; if (bus.valid_out !== 2'b00 || bus.pc_out !== 32'h0 || bus.interlock !== 1'b0) begin failures++; $display("[TB] FAIL rsplit_async got valid=%b pc=%h il=%b exp 00/0/0", bus.valid_out, bus.pc_out, bus.interlock); end
        rstn = 1'b1;
        drive(32'h90, mk(ADD, 5'd25, 5'd1, 5'd2), mk(ADD, 5'd26, 5'd3, 5'd4));
        checks++; if (bus.interlock !== 1'b0) begin failures++; $display("[TB] FAIL rsplit_interlock got=%b exp=0", bus.interlock); end
        tick();
        checks++; if (bus.valid_out !== 2'b11 || bus.pc_out !== 32'h90) begin failures++; $display("[TB] FAIL rsplit_next got valid=%b pc=%h exp 11/90", bus.valid_out, bus.pc_out); end
`ifdef DECODE_STATS_EN
        checks++; if (bubble_cnt !== 32'd0 || split_cnt !== 32'd0) begin failures++; $display("[TB] FAIL rsplit_stats got=%0d/%0d exp=0/0", bubble_cnt, split_cnt); end
`endif
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        $display("[TB] decode_issue bench start");
        test_reset();
        test_pair();
        test_load_use();
        test_split();
        test_flush_split();
        test_stall();
        test_reset_split();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
